// File: rtl/eth_loopback_line_splitter_core.sv
// eth_loopback_line_splitter_core: duplicates the XGMII word stream onto two Avalon-ST ports with per-port FIFO and frame-safe drop.
// Port B (monitor) exists only when LINE_SPLITTER_MONITOR_PORT_EN is defined.
module eth_loopback_line_splitter_port #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [71:0]      in_data,
  input  logic             in_valid,
  output logic [71:0]      data,
  output logic             valid,
  input  logic             ready,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] PASS = 1'b0;
  localparam logic [0:0] DROP = 1'b1;
  localparam logic [71:0] IDLE = {8'hFF, {8{8'h07}}};
  logic [71:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic [0:0] state;
  logic full, push, pop, drop, idle;
  assign idle  = in_data == IDLE;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign valid = wp != rp;
  // leaving DROP requires an idle so a truncated frame is never emitted
  assign push  = in_valid && !full && (state == PASS || idle);
  assign drop  = in_valid && !push;
  assign pop   = ready && valid;
  assign data  = valid ? mem[rp[AW-1:0]] : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp       <= '0;
      rp       <= '0;
      state    <= PASS;
      drop_cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      state    <= push ? PASS : drop ? DROP : state;
      drop_cnt <= cnt_clear ? '0 : (drop && !(&drop_cnt)) ? drop_cnt + 1'b1 : drop_cnt;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= in_data;
endmodule

module eth_loopback_line_splitter_core #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [71:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [71:0]      a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [71:0]      b_data,
  output logic             b_valid,
  input  logic             b_ready,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] drop_cnt_a,
  output logic [CNT_W-1:0] drop_cnt_b
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) in_ready <= 1'b0;
    else in_ready <= 1'b1;
  eth_loopback_line_splitter_port #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_a (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .data(a_data), .valid(a_valid), .ready(a_ready),
    .cnt_clear(cnt_clear), .drop_cnt(drop_cnt_a)
  );
`ifdef LINE_SPLITTER_MONITOR_PORT_EN
  eth_loopback_line_splitter_port #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_b (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .data(b_data), .valid(b_valid), .ready(b_ready),
    .cnt_clear(cnt_clear), .drop_cnt(drop_cnt_b)
  );
`else
  logic unused_b_ready;
  assign unused_b_ready = b_ready;
  assign b_data     = '0;
  assign b_valid    = 1'b0;
  assign drop_cnt_b = '0;
`endif
endmodule

// File: doc/eth_loopback_line_splitter_core.md
# eth_loopback_line_splitter_core

Duplicates the 72-bit XGMII-style word stream from the line splitter timing adapter onto two Avalon-ST outputs: port A, the loopback path, and port B, the monitor path. Each output has its own small FIFO, so either consumer can backpressure independently. The upstream side is never backpressured. On overflow, an output discards beats until the next idle word, so it never emits a truncated frame, and the discarded beats are counted.

## Interface
Parameters:
- DEPTH, 4, entries per output FIFO; power of two, ≥2.
- CNT_W, 16, width of the saturating drop counters.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  72  word; lane i data = in_data[8i+7:8i], ctrl bit i = in_data[64+i], i=0..7.
- in_valid  in  1  input beat qualifier.
- in_ready  out  1  constant 1 outside reset; informational only.
- a_data  out  72  port A head-of-FIFO word.
- a_valid  out  1  port A FIFO non-empty.
- a_ready  in  1  port A pop.
- b_data  out  72  port B head-of-FIFO word.
- b_valid  out  1  port B FIFO non-empty.
- b_ready  in  1  port B pop.
- cnt_clear  in  1  synchronous clear of both drop counters.
- drop_cnt_a  out  CNT_W  port A beats discarded, saturating.
- drop_cnt_b  out  CNT_W  port B beats discarded, saturating.

## Operation
- Input beat: in_valid=1 at a rising clk edge. It is offered to both ports in the same cycle.
- Idle word: ctrl = 8'hFF and every data byte = 8'h07.
- Each port has an independent 2-state FSM, PASS and DROP; reset state is PASS.
- PASS, beat arrives, FIFO not full: the beat is written.
- PASS, beat arrives, FIFO full: the beat is discarded, the counter increments, and the FSM goes to DROP.
- DROP, beat is not idle: the beat is discarded and the counter increments.
- DROP, beat is idle, FIFO not full: the idle word is written and the FSM goes to PASS.
- DROP, beat is idle, FIFO full: the beat is discarded, the counter increments, and the FSM stays in DROP.
- Full is evaluated from occupancy at the start of the cycle. A push and a pop in the same cycle on a full FIFO therefore still discards the push.
- Push and pop in the same cycle on a non-empty, non-full FIFO leaves occupancy unchanged.
- Pop on an empty FIFO is ignored.
- Pointers: log2(DEPTH)+1 bits with natural wrap. Full means the MSBs differ and the low bits are equal; empty means all bits are equal.
- Counters saturate at all-ones.
- cnt_clear zeroes both counters. If cnt_clear and a drop occur in the same cycle, the clear wins and the counter reads 0.
- One port's state never affects the other port.

## Timing
- Reset values: in_ready=0, a_valid=b_valid=0, a_data=b_data=0, drop counters 0, FSMs in PASS, FIFOs empty.
- in_ready goes to 1 on the first clk edge after reset_n deasserts.
- Latency: a beat written at edge N is visible on x_data/x_valid after edge N. This is one cycle from in_valid to out_valid when the FIFO was empty.
- x_valid and x_data are registered/RAM-head outputs with no combinational path from in_*.
- x_data holds stable while x_valid=1 and x_ready=0.
- Reset asserted mid-stream empties both FIFOs and returns the FSMs to PASS immediately. Counters clear.
- Sustained throughput is one beat per cycle per port when x_ready=1 continuously, with occupancy ≤1.

## Configuration
- Macro: LINE_SPLITTER_MONITOR_PORT_EN.
- Defined: port B FIFO, FSM and counter exist as described.
- Not defined: port B logic is not instantiated. b_valid=0, b_data=0 and drop_cnt_b=0 constantly, and b_ready is ignored. Port A behaviour is identical in both builds.

## Test plan
- **Reset:** assert reset_n=0 with in_valid=1 -> all outputs 0. One edge after release, in_ready=1.
- **Streaming:** a_ready=b_ready=1, 10 consecutive beats 0x00_0000000000000001..0A -> both ports emit the same 10 words in order, each one cycle after input, and both counters stay 0.
- **Port B overflow:** DEPTH=4, b_ready=0, send start word (ctrl 8'h01, lane0 0xFB), then 5 data beats, then an idle word.
  - Port B holds the first 4 beats and drops beat 5 and the rest; drop_cnt_b=3.
  - The idle is dropped because port B is still full, so the FSM stays in DROP.
  - Release b_ready, then send another idle -> port B outputs 4 words followed by the idle.
  - Port A receives all 7 beats and drop_cnt_a=0.
- **Full + simultaneous pop:** FIFO full, a_ready=1 and a new beat in the same cycle -> the beat is dropped, drop_cnt_a=1, and occupancy goes to 3.
- **Counter saturation/clear:** CNT_W=4, force 20 drops -> counter reads 4'hF. Assert cnt_clear during a drop cycle -> counter reads 0.
- **Macro off:** build without LINE_SPLITTER_MONITOR_PORT_EN, stream 10 beats -> port A passes all 10; b_valid and drop_cnt_b stay 0.
